npxl_empfaenger: RTL and testbench
==================================

Name: npxl_empfaenger

Overview:
- Receives and decodes a WS2812 ("NeoPixel") single-wire stream, as produced by npxl_treiber, back into 24-bit color words.
- Counts words per frame and flags frame-end on the reset/latch gap.
- Used in loopback with npxl_treiber for self-check of the VU meter LED chain, and as a bench monitor.
- Runs on the 48 MHz system clock (~20.8 ns per cycle).

Parameters:
- LEDS, 5: expected color words per frame; index width is $clog2(LEDS+1).
- T_MIN, 6: minimum valid high time in cycles; shorter highs are glitches.
- T_THRESH, 29: high time >= T_THRESH decodes as '1', otherwise '0' (~0.6 us).
- T_MAX, 60: high time > T_MAX is a timing error (~1.25 us).
- T_RESET, 2400: low time >= T_RESET ends the frame (50 us).

Ports:
- i_clk  in  1  system clock, 48 MHz
- i_rst  in  1  synchronous reset, active-high
- i_npxl_data  in  1  serial WS2812 line, asynchronous
- o_color_data  out  24  last decoded word, MSB first as transmitted (G[7:0],R[7:0],B[7:0])
- o_valid  out  1  one-cycle pulse, o_color_data/o_led_idx valid
- o_led_idx  out  $clog2(LEDS+1)  index of word within frame, 0-based
- o_frame_done  out  1  one-cycle pulse at reset-gap detection
- o_led_cnt  out  $clog2(LEDS+1)  words received in completed frame, valid with o_frame_done
- o_err  out  3  [0] timing/glitch, [1] truncated word, [2] overflow (>LEDS words); valid with o_frame_done

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - All outputs go to 0; shift register, bit counter, word counter and flags clear.
  - State goes to IDLE; line history is treated as low.
  - Reset mid-word discards the partial word with no pulse.
- Input path:
  - 2-flop synchronizer, then edge detect on the synchronized signal.
  - High and low counters count synchronized cycles and saturate at T_RESET; no wrap.
- States:
  - IDLE: waits for the first rising edge; the low counter is ignored, so no frame_done is produced without data. Rising edge -> HIGH.
  - HIGH: counts high cycles; falling edge -> LOW with a bit decision.
  - LOW: counts low cycles; rising edge -> HIGH; low count reaching T_RESET -> LATCH.
  - LATCH: one cycle; pulses o_frame_done, then -> IDLE.
- Bit decision on a falling edge, with high count h:
  - h < T_MIN: no bit shifted; sets err[0].
  - T_MIN <= h < T_THRESH: shift '0'.
  - T_THRESH <= h <= T_MAX: shift '1'.
  - h > T_MAX: shift '1' and set err[0].
- Word handling:
  - Shift left, new bit into LSB.
  - On the 24th bit, in the cycle after the falling edge is seen on the synchronized signal, o_valid=1 for one cycle.
  - o_color_data and o_led_idx update in that same cycle and hold until the next word.
  - The word counter then increments and the bit counter returns to 0.
- Overflow:
  - The word counter saturates at LEDS.
  - Words beyond LEDS are still emitted with o_led_idx=LEDS and set err[2].
- LATCH cycle:
  - o_led_cnt = word counter.
  - o_err = accumulated flags, with err[1] set if the bit counter != 0 (partial word discarded).
  - o_led_cnt and o_err hold until the next LATCH.
  - Internal counters and flags clear entering IDLE.
- Line stuck high:
  - The high counter saturates; no bit until the falling edge, which then sets err[0].
- Latency: rising edge on i_npxl_data to the counter starting is 3 cycles; the decode pipeline is fixed, so relative timing is exact.

Test Plan:
- Loopback npxl_treiber (LEDS=5) -> receiver, words 0x000700 for idx 3..4 and 0 otherwise, frame latched:
  - Five o_valid pulses, idx 0..4, data 0,0,0,0x000700,0x000700.
  - o_frame_done with o_led_cnt=5, o_err=0.
- Direct drive, 24 bits of 0xA5C3F0 with h=19 for 0 and h=38 for 1, low 60-h, then 2400 low:
  - o_valid with 0xA5C3F0, idx 0.
  - frame_done with led_cnt=1, err=0.
- 4-cycle high glitch mid-word, then the remaining bits:
  - Glitch produces no bit shift.
  - frame_done carries err[0]=1, and the word decodes correctly.
- 12 bits then 2400 low:
  - No o_valid.
  - frame_done with led_cnt=0, err=3'b010.
- 6 words in one frame:
  - 6th valid with idx=5.
  - frame_done with led_cnt=5, err[2]=1.
- Assert i_rst after bit 10 of a word, then send a full word and latch:
  - All outputs are 0 during reset.
  - After reset, the word decodes at idx 0 and led_cnt=1.

Source files
------------

// File: rtl/npxl_empfaenger.sv
// WS2812 single-wire receiver: decodes the serial line back into 24-bit colour words,
// numbers them within a frame and reports frame end with word count and error flags.
module npxl_empfaenger #(
  parameter int unsigned LEDS     = 5,
  parameter int unsigned T_MIN    = 6,
  parameter int unsigned T_THRESH = 29,
  parameter int unsigned T_MAX    = 60,
  parameter int unsigned T_RESET  = 2400
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_npxl_data,
  output logic [23:0]                 o_color_data,
  output logic                        o_valid,
  output logic [$clog2(LEDS+1)-1:0]   o_led_idx,
  output logic                        o_frame_done,
  output logic [$clog2(LEDS+1)-1:0]   o_led_cnt,
  output logic [2:0]                  o_err
);

  localparam int unsigned IW = $clog2(LEDS + 1);
  localparam int unsigned CW = $clog2(T_RESET + 1);

  localparam logic [CW-1:0] TMin    = CW'(T_MIN);
  localparam logic [CW-1:0] TThresh = CW'(T_THRESH);
  localparam logic [CW-1:0] TMax    = CW'(T_MAX);
  localparam logic [CW-1:0] TReset  = CW'(T_RESET);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [IW-1:0] LedsMax = IW'(LEDS);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_e;

  state_e         state_q;
  logic           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]  hcnt_q, lcnt_q;
  logic [22:0]    shift_q;
  logic [4:0]     bcnt_q;
  logic [IW-1:0]  wcnt_q;
  logic           err_timing_q, err_ovf_q;

  logic           rise, fall;
  logic [CW-1:0]  hcnt_sat, lcnt_sat;
  logic           bit_ok, bit_val, bit_long;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_npxl_data;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    rise     = sync2_q & ~prev_q;
    fall     = ~sync2_q & prev_q;
    hcnt_sat = (hcnt_q >= TReset) ? TReset : hcnt_q + CntOne;
    lcnt_sat = (lcnt_q >= TReset) ? TReset : lcnt_q + CntOne;
    bit_ok   = hcnt_q >= TMin;
    bit_val  = hcnt_q >= TThresh;
    bit_long = hcnt_q > TMax;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      shift_q      <= '0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      err_timing_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      o_color_data <= '0;
      o_valid      <= 1'b0;
      o_led_idx    <= '0;
      o_frame_done <= 1'b0;
      o_led_cnt    <= '0;
      o_err        <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StHigh;
            hcnt_q  <= CntOne;
          end
        end
        StHigh: begin
          if (fall) begin
            state_q <= StLow;
            lcnt_q  <= CntOne;
            if (!bit_ok) begin
              err_timing_q <= 1'b1;
            end else begin
              if (bit_long) err_timing_q <= 1'b1;
              if (bcnt_q == 5'd23) begin
                o_valid      <= 1'b1;
                o_color_data <= {shift_q, bit_val};
                o_led_idx    <= wcnt_q;
                bcnt_q       <= '0;
                if (wcnt_q == LedsMax) err_ovf_q <= 1'b1;
                else                   wcnt_q    <= wcnt_q + IW'(1);
              end else begin
                shift_q <= {shift_q[21:0], bit_val};
                bcnt_q  <= bcnt_q + 5'd1;
              end
            end
          end else begin
            hcnt_q <= hcnt_sat;
          end
        end
        StLow: begin
          if (rise) begin
            state_q <= StHigh;
            hcnt_q  <= CntOne;
          end else begin
            lcnt_q <= lcnt_sat;
            if (lcnt_sat == TReset) state_q <= StLatch;
          end
        end
        StLatch: begin
          o_frame_done <= 1'b1;
          o_led_cnt    <= wcnt_q;
          o_err        <= {err_ovf_q, bcnt_q != 5'd0, err_timing_q};
          wcnt_q       <= '0;
          bcnt_q       <= '0;
          shift_q      <= '0;
          err_timing_q <= 1'b0;
          err_ovf_q    <= 1'b0;
          // An edge landing in the latch cycle would otherwise be lost from the history flop.
          if (rise) begin
            state_q <= StHigh;
            hcnt_q  <= CntOne;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_npxl_empfaenger.sv
// Directed bench for npxl_empfaenger: drives WS2812 waveforms and checks decoded words
// and frame summaries against hand-computed values.
`timescale 1ns/1ps
module tb_npxl_empfaenger;

  logic        clk;
  logic        rst;
  logic        line;
  logic [23:0] color_data;
  logic        valid;
  logic [2:0]  led_idx;
  logic        frame_done;
  logic [2:0]  led_cnt;
  logic [2:0]  err;

  int checks   = 0;
  int failures = 0;

  logic [23:0] vq_data[$];
  logic [2:0]  vq_idx[$];
  logic [2:0]  fq_cnt[$];
  logic [2:0]  fq_err[$];

  npxl_empfaenger dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_npxl_data  (line),
    .o_color_data (color_data),
    .o_valid      (valid),
    .o_led_idx    (led_idx),
    .o_frame_done (frame_done),
    .o_led_cnt    (led_cnt),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        vq_data.push_back(color_data);
        vq_idx.push_back(led_idx);
      end
      if (frame_done) begin
        fq_cnt.push_back(led_cnt);
        fq_err.push_back(err);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int h);
    line = 1'b1;
    repeat (h) @(negedge clk);
    line = 1'b0;
    repeat (60 - h) @(negedge clk);
  endtask

  // Sends bits first..last of a word, counted MSB-first from 0.
  task automatic send_bits(input logic [23:0] data, input int first, input int last,
                           input int h0, input int h1);
    for (int i = first; i <= last; i++) send_bit(data[23-i] ? h1 : h0);
  endtask

  task automatic wait_frame(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (fq_cnt.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, ok, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic clear_q();
    vq_data.delete();
    vq_idx.delete();
    fq_cnt.delete();
    fq_err.delete();
  endtask

  initial begin
    logic [23:0] words [5];
    words = '{24'h0, 24'h0, 24'h0, 24'h000700, 24'h000700};
    rst  = 1'b1;
    line = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", color_data, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Loopback-style frame with driver timing (0.35/0.7 us highs).
    clear_q();
    for (int w = 0; w < 5; w++) send_bits(words[w], 0, 23, 17, 34);
    wait_frame("t1_frame");
    chk("t1_nvalid", vq_data.size(), 5);
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("t1_data%0d", w), vq_data[w], words[w]);
      chk($sformatf("t1_idx%0d", w), vq_idx[w], w);
    end
    chk("t1_cnt", fq_cnt[0], 5);
    chk("t1_err", fq_err[0], 0);

    // Single word, direct drive.
    clear_q();
    send_bits(24'hA5C3F0, 0, 23, 19, 38);
    wait_frame("t2_frame");
    chk("t2_nvalid", vq_data.size(), 1);
    chk("t2_data", vq_data[0], 24'hA5C3F0);
    chk("t2_idx", vq_idx[0], 0);
    chk("t2_cnt", fq_cnt[0], 1);
    chk("t2_err", fq_err[0], 0);

    // Short glitch mid-word must not shift a bit.
    clear_q();
    send_bits(24'h3C5A81, 0, 11, 19, 38);
    line = 1'b1;
    repeat (4) @(negedge clk);
    line = 1'b0;
    repeat (20) @(negedge clk);
    send_bits(24'h3C5A81, 12, 23, 19, 38);
    wait_frame("t3_frame");
    chk("t3_nvalid", vq_data.size(), 1);
    chk("t3_data", vq_data[0], 24'h3C5A81);
    chk("t3_cnt", fq_cnt[0], 1);
    chk("t3_err", fq_err[0], 3'b001);

    // Truncated word.
    clear_q();
    send_bits(24'hFFF000, 0, 11, 19, 38);
    wait_frame("t4_frame");
    chk("t4_nvalid", vq_data.size(), 0);
    chk("t4_cnt", fq_cnt[0], 0);
    chk("t4_err", fq_err[0], 3'b010);

    // Six words into a five-LED frame.
    clear_q();
    for (int w = 0; w < 6; w++) send_bits(24'h010203 + 24'(w), 0, 23, 19, 38);
    wait_frame("t5_frame");
    chk("t5_nvalid", vq_data.size(), 6);
    chk("t5_idx4", vq_idx[4], 4);
    chk("t5_idx5", vq_idx[5], 5);
    chk("t5_data5", vq_data[5], 24'h010208);
    chk("t5_cnt", fq_cnt[0], 5);
    chk("t5_err", fq_err[0], 3'b100);

    // Reset in the middle of a word.
    clear_q();
    send_bits(24'hFFFFFF, 0, 9, 19, 38);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_data", color_data, 0);
    chk("t6_rst_idx", led_idx, 0);
    chk("t6_rst_fdone", frame_done, 0);
    chk("t6_rst_cnt", led_cnt, 0);
    chk("t6_rst_err", err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(24'h5AA55A, 0, 23, 19, 38);
    wait_frame("t6_frame");
    chk("t6_nvalid", vq_data.size(), 1);
    chk("t6_data", vq_data[0], 24'h5AA55A);
    chk("t6_idx", vq_idx[0], 0);
    chk("t6_cnt", fq_cnt[0], 1);
    chk("t6_err", fq_err[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
